macrocell_ff: RTL and testbench
===============================

# macrocell_ff

Cycle-based model of the macrocell storage element in the simulated CPLD. It consumes the flip-flop enable and flip-flop clock produced by the product-term-4 routing stage (`ffen_v`, `ffclk_v`), together with the macrocell sum-term data and the asynchronous reset/preset product terms. It implements D, T, latch and bypass behaviour on the simulator tick `gclk`. `ffclk_v` is an ordinary sampled signal here; its rising edges are detected on `gclk`.

## Interface
Parameters:
- `INIT`, default `1'b0`: power-up / reset value of the storage bit.

Ports (one clock; reset is asynchronous and active-high):
- `gclk`  input  1  simulator tick; every register in the block updates on its rising edge.
- `rst`  input  1  asynchronous, active-high global reset.
- `ff_mode`  input  2  fuse configuration: 00 D flip-flop, 01 T flip-flop, 10 transparent latch, 11 combinational bypass.
- `ffen_v`  input  1  clock enable from the pt4 routing stage.
- `ffclk_v`  input  1  flip-flop clock from the pt4 routing stage.
- `d_v`  input  1  sum-term data (D input, or T input in T mode).
- `ar_v`  input  1  asynchronous-reset product term, already qualified by its fuse.
- `ap_v`  input  1  asynchronous-preset product term, already qualified by its fuse.
- `q_v`  output  1  macrocell output (registered value, or `d_v` in bypass mode).
- `fb_v`  output  1  feedback to the interconnect; always the stored bit, never the bypass value.
- `clk_edge_v`  output  1  one-tick pulse, high in the tick after a qualified `ffclk_v` rising edge is detected.

## Operation
Internal state:
- `ffclk_prev` (1 bit): previous sample of `ffclk_v`.
- `qreg` (1 bit): the stored bit.
- `edge_r` (1 bit): drives `clk_edge_v`.

Edge detection:
- `rise = ffclk_v & ~ffclk_prev`.
- `ffclk_prev` takes `ffclk_v` every tick.

Update of `qreg` at each `gclk` rise, highest priority first:
1. `ar_v`=1 → `qreg`=0. This applies even if `ap_v`=1 in the same tick; reset beats preset.
2. `ap_v`=1 → `qreg`=1.
3. Mode 00: `rise & ffen_v` → `qreg`=`d_v`.
4. Mode 01: `rise & ffen_v & d_v` → `qreg`=~`qreg`.
5. Mode 10: `ffclk_v & ffen_v` (level, not edge) → `qreg`=`d_v`; otherwise hold.
6. Mode 11: `qreg` holds; `ar_v`/`ap_v` still act on it.
7. Otherwise `qreg` holds.

Edge pulse:
- `edge_r` = `rise & ffen_v`, independent of mode, and suppressed (0) when `ar_v` or `ap_v` is 1.

Outputs:
- `q_v` = `d_v` in mode 11 (combinational); otherwise `qreg`.
- `fb_v` = `qreg`.

Mode changes:
- `ff_mode` is fuse-static in normal use.
- A change mid-run takes effect on the next tick.
- `qreg` keeps its value across the change.

## Timing
Reset:
- While `rst`=1, immediately and without waiting for `gclk`: `qreg`=`INIT`, `ffclk_prev`=1, `edge_r`=0.
- Resulting outputs: `q_v`=`INIT` (or `d_v` in mode 11), `fb_v`=`INIT`, `clk_edge_v`=0.
- Because `ffclk_prev` resets to 1, an `ffclk_v` that is already high at reset release is not an edge. The first edge requires `ffclk_v` to be seen low for at least one tick.
- Reset asserted mid-operation discards any pending edge.

Latency:
- `ffclk_v` 0→1 is sampled at tick N.
- `qreg`, `fb_v` and `q_v` show the new value after tick N.
- `clk_edge_v` is high for exactly the one tick following N.

Boundary conditions:
- `ffen_v` is sampled in the same tick as the edge. An enable that arrives one tick late does not capture.
- `ffclk_v` held high for many ticks gives exactly one edge.
- `ffclk_v` toggling every tick gives an edge every second tick.
- `ar_v`/`ap_v` are synchronous to `gclk` in this model. They override a coincident edge, and no capture is retained after they drop.
- Latch mode with `ffclk_v`=`ffen_v`=1: `q_v` follows `d_v` with a 1-tick delay.

## Test plan
- Reset with `INIT`=1, `rst` pulse while `ffclk_v`=1 → `q_v`=`fb_v`=1, `clk_edge_v`=0. Release with `ffclk_v` still 1 → no capture.
- Mode 00, `d_v`=1, `ffen_v`=1, `ffclk_v` 0→1 at tick 5 → `q_v`=1 from tick 6, `clk_edge_v` high only in tick 6. Same stimulus with `ffen_v`=0 → `q_v` stays 0 and no pulse.
- Mode 01, `d_v`=1, `ffclk_v` square wave of period 4 ticks for 3 periods → `q_v` toggles 0→1→0→1, with one toggle per rising edge.
- `ar_v`=`ap_v`=1 coincident with an edge and `d_v`=1 → `q_v`=0. Then `ap_v` alone → `q_v`=1.
- Mode 10, `ffclk_v`=`ffen_v`=1, `d_v` sequence 1,0,1 → `q_v`=1,0,1, each one tick later. Drop `ffclk_v` → `q_v` holds.
- Mode 11, `d_v` toggling → `q_v`=`d_v` in the same tick, while `fb_v` keeps `qreg` (set it to 1 via `ap_v` and check it stays 1).

Source files
------------

// File: rtl/macrocell_ff.sv
// macrocell_ff
// Storage element of one CPLD macrocell, evaluated once per simulator tick
// (gclk). Supports D flip-flop, T flip-flop, transparent latch and
// combinational bypass. The macrocell clock ffclk_v is an ordinary sampled
// signal; its rising edges are detected against the previous gclk sample.
//
// Ports
//   gclk        simulator tick, all registers update on its rising edge
//   rst         asynchronous active-high global reset
//   ff_mode     00 D, 01 T, 10 latch, 11 bypass
//   ffen_v      clock enable from the pt4 routing stage
//   ffclk_v     flip-flop clock from the pt4 routing stage
//   d_v         sum-term data (T input in T mode)
//   ar_v        async-reset product term (sampled on gclk), beats ap_v
//   ap_v        async-preset product term (sampled on gclk)
//   q_v         macrocell output: stored bit, or d_v in bypass mode
//   fb_v        feedback to the interconnect, always the stored bit
//   clk_edge_v  one-tick pulse after a qualified ffclk_v rising edge
module macrocell_ff #(
  parameter logic INIT = 1'b0
) (
  input  logic       gclk,
  input  logic       rst,
  input  logic [1:0] ff_mode,
  input  logic       ffen_v,
  input  logic       ffclk_v,
  input  logic       d_v,
  input  logic       ar_v,
  input  logic       ap_v,
  output logic       q_v,
  output logic       fb_v,
  output logic       clk_edge_v
);

  localparam logic [1:0] MODE_D     = 2'b00;
  localparam logic [1:0] MODE_T     = 2'b01;
  localparam logic [1:0] MODE_LATCH = 2'b10;
  localparam logic [1:0] MODE_BYP   = 2'b11;

  logic ffclk_prev_q;
  logic qreg_q, qreg_d;
  logic edge_q, edge_d;

  logic rise;
  logic fire;

  assign rise = ffclk_v & ~ffclk_prev_q;
  assign fire = rise & ffen_v;

  always_comb begin
    qreg_d = qreg_q;
    // Preset/reset terms override any coincident capture; reset beats preset.
    if (ar_v) begin
      qreg_d = 1'b0;
    end else if (ap_v) begin
      qreg_d = 1'b1;
    end else begin
      unique case (ff_mode)
        MODE_D: begin
          if (fire) qreg_d = d_v;
        end
        MODE_T: begin
          if (fire && d_v) qreg_d = ~qreg_q;
        end
        MODE_LATCH: begin
          // Level-sensitive: transparent while clock and enable are both high.
          if (ffclk_v && ffen_v) qreg_d = d_v;
        end
        MODE_BYP: begin
          qreg_d = qreg_q;
        end
        default: begin
          qreg_d = qreg_q;
        end
      endcase
    end
  end

  assign edge_d = fire & ~ar_v & ~ap_v;

  // ffclk_prev resets high so a clock already high at reset release is not
  // mistaken for an edge.
  always_ff @(posedge gclk or posedge rst) begin
    if (rst) begin
      ffclk_prev_q <= 1'b1;
      qreg_q       <= INIT;
      edge_q       <= 1'b0;
    end else begin
      ffclk_prev_q <= ffclk_v;
      qreg_q       <= qreg_d;
      edge_q       <= edge_d;
    end
  end

  assign q_v        = (ff_mode == MODE_BYP) ? d_v : qreg_q;
  assign fb_v       = qreg_q;
  assign clk_edge_v = edge_q;

endmodule

// File: tb/tb_macrocell_ff.sv
module tb_macrocell_ff;

  localparam logic INIT_VAL = 1'b1;

  logic       gclk;
  logic       rst;
  logic [1:0] ff_mode;
  logic       ffen_v;
  logic       ffclk_v;
  logic       d_v;
  logic       ar_v;
  logic       ap_v;
  logic       q_v;
  logic       fb_v;
  logic       clk_edge_v;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit m_prev;
  bit m_q;
  bit m_edge;

  macrocell_ff #(.INIT(INIT_VAL)) dut (
    .gclk      (gclk),
    .rst       (rst),
    .ff_mode   (ff_mode),
    .ffen_v    (ffen_v),
    .ffclk_v   (ffclk_v),
    .d_v       (d_v),
    .ar_v      (ar_v),
    .ap_v      (ap_v),
    .q_v       (q_v),
    .fb_v      (fb_v),
    .clk_edge_v(clk_edge_v)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  function automatic void model_reset();
    m_q    = INIT_VAL;
    m_prev = 1'b1;
    m_edge = 1'b0;
  endfunction

  // One tick of the behavioural rules: priority list for the stored bit,
  // qualified-edge pulse for clk_edge_v.
  function automatic void model_tick();
    bit rose;
    bit fire;
    rose   = ffclk_v && !m_prev;
    fire   = rose && ffen_v;
    m_edge = fire && !ar_v && !ap_v;
    if (ar_v)      m_q = 1'b0;
    else if (ap_v) m_q = 1'b1;
    else begin
      case (ff_mode)
        2'd0: if (fire) m_q = d_v;
        2'd1: if (fire) m_q = m_q ^ d_v;
        2'd2: if (ffclk_v && ffen_v) m_q = d_v;
        default: ;
      endcase
    end
    m_prev = ffclk_v;
  endfunction

  function automatic logic [2:0] model_out();
    return {((ff_mode == 2'd3) ? d_v : m_q), m_q, m_edge};
  endfunction

  task automatic step();
    @(posedge gclk);
    #1;
    if (rst) model_reset();
    else     model_tick();
  endtask

  task automatic drive(input bit clk, input bit en, input bit d, input bit ar, input bit ap);
    ffclk_v = clk;
    ffen_v  = en;
    d_v     = d;
    ar_v    = ar;
    ap_v    = ap;
  endtask

  task automatic test_reset();
    logic [2:0] obs;
    ff_mode = 2'd0;
    drive(1, 1, 0, 0, 0);
    rst = 1'b1;
    #1;
    model_reset();
    obs = {q_v, fb_v, clk_edge_v};
    total++;
    if (obs !== 3'b110) begin
      bad++;
      $display("FAIL reset_async got=%b want=110", obs);
    end
    step();
    rst = 1'b0;
    for (int t = 0; t < 3; t++) begin
      step();
      obs = {q_v, fb_v, clk_edge_v};
      total++;
      if (obs !== 3'b110) begin
        bad++;
        $display("FAIL reset_release_no_capture t=%0d got=%b want=110", t, obs);
      end
    end
  endtask

  task automatic test_d_capture();
    logic [2:0] obs;
    logic [2:0] want;
    ff_mode = 2'd0;
    // clear stored bit, clock low
    drive(0, 0, 0, 1, 0);
    step();
    // ffclk 0->1 sampled at t=5 with enable
    for (int t = 1; t <= 8; t++) begin
      drive(t >= 5, 1, 1, 0, 0);
      step();
      obs  = {q_v, fb_v, clk_edge_v};
      want = {(t >= 5) ? 2'b11 : 2'b00, (t == 5) ? 1'b1 : 1'b0};
      total++;
      if (obs !== want) begin
        bad++;
        $display("FAIL d_capture_en t=%0d got=%b want=%b", t, obs, want);
      end
    end
    drive(0, 0, 0, 1, 0);
    step();
    for (int t = 1; t <= 8; t++) begin
      drive(t >= 5, 0, 1, 0, 0);
      step();
      obs = {q_v, fb_v, clk_edge_v};
      total++;
      if (obs !== 3'b000) begin
        bad++;
        $display("FAIL d_capture_noen t=%0d got=%b want=000", t, obs);
      end
    end
    // enable arriving one tick after the edge must not capture
    drive(0, 0, 1, 0, 0);
    step();
    drive(1, 0, 1, 0, 0);
    step();
    drive(1, 1, 1, 0, 0);
    step();
    obs = {q_v, fb_v, clk_edge_v};
    total++;
    if (obs !== 3'b000) begin
      bad++;
      $display("FAIL late_enable got=%b want=000", obs);
    end
  endtask

  task automatic test_toggle();
    logic [2:0] obs;
    int         edges;
    bit         seen[$];
    ff_mode = 2'd1;
    drive(0, 0, 0, 1, 0);
    step();
    edges = 0;
    for (int t = 0; t < 12; t++) begin
      drive((t % 4) >= 2, 1, 1, 0, 0);
      step();
      obs = {q_v, fb_v, clk_edge_v};
      total++;
      if (obs !== model_out()) begin
        bad++;
        $display("FAIL toggle t=%0d got=%b want=%b", t, obs, model_out());
      end
      if (clk_edge_v === 1'b1) begin
        edges++;
        seen.push_back(q_v);
      end
    end
    total++;
    if (edges != 3 || seen.size() != 3 || seen[0] != 1'b1 || seen[1] != 1'b0 || seen[2] != 1'b1) begin
      bad++;
      $display("FAIL toggle_sequence edges=%0d want=3 (q after edges should be 1,0,1)", edges);
    end
  endtask

  task automatic test_ar_ap();
    logic [2:0] obs;
    ff_mode = 2'd0;
    drive(0, 1, 1, 0, 0);
    step();
    drive(1, 1, 1, 1, 1);
    step();
    obs = {q_v, fb_v, clk_edge_v};
    total++;
    if (obs !== 3'b000) begin
      bad++;
      $display("FAIL ar_beats_ap_and_edge got=%b want=000", obs);
    end
    drive(1, 1, 1, 0, 1);
    step();
    obs = {q_v, fb_v, clk_edge_v};
    total++;
    if (obs !== 3'b110) begin
      bad++;
      $display("FAIL ap_alone got=%b want=110", obs);
    end
    drive(1, 1, 0, 0, 0);
    step();
    obs = {q_v, fb_v, clk_edge_v};
    total++;
    if (obs !== 3'b110) begin
      bad++;
      $display("FAIL no_retained_capture got=%b want=110", obs);
    end
  endtask

  task automatic test_latch();
    logic [2:0] obs;
    bit         seq[3] = '{1'b1, 1'b0, 1'b1};
    ff_mode = 2'd2;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, seq[i], 0, 0);
      step();
      obs = {q_v, fb_v, clk_edge_v};
      total++;
      if (obs[2] !== seq[i] || obs[1] !== seq[i]) begin
        bad++;
        $display("FAIL latch_follow i=%0d got=%b want_q=%b", i, obs, seq[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, i[0], 0, 0);
      step();
      total++;
      if (q_v !== 1'b1) begin
        bad++;
        $display("FAIL latch_hold i=%0d got=%b want=1", i, q_v);
      end
    end
  endtask

  task automatic test_bypass();
    ff_mode = 2'd3;
    drive(0, 1, 0, 1, 0);
    step();
    drive(0, 1, 0, 0, 1);
    step();
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      d_v     = i[0];
      ffclk_v = i[1];
      #1;
      total++;
      if (q_v !== i[0] || fb_v !== 1'b1) begin
        bad++;
        $display("FAIL bypass i=%0d got_q=%b want_q=%b got_fb=%b want_fb=1", i, q_v, i[0], fb_v);
      end
      step();
    end
  endtask

  task automatic test_random();
    logic [2:0] obs;
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        obs = {q_v, fb_v, clk_edge_v};
        total++;
        if (obs !== model_out()) begin
          bad++;
          $display("FAIL random_reset t=%0d got=%b want=%b", t, obs, model_out());
        end
        rst = 1'b0;
      end
      if ($urandom_range(0, 39) == 0) ff_mode = 2'($urandom_range(0, 3));
      drive($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 1),
            $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
      step();
      obs = {q_v, fb_v, clk_edge_v};
      total++;
      if (obs !== model_out()) begin
        bad++;
        $display("FAIL random t=%0d mode=%0d got=%b want=%b", t, ff_mode, obs, model_out());
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    ff_mode = 2'd0;
    drive(0, 0, 0, 0, 0);
    model_reset();
    test_reset();
    test_d_capture();
    test_toggle();
    test_ar_ap();
    test_latch();
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
